// File: rtl/uart_cmd_framer_pkg.sv
// Shared constants, FSM state encoding and frame acceptance check for the
// UART command framer.
package uart_cmd_framer_pkg;

    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam logic [7:0] OPC_READ     = 8'h01;
    localparam logic [7:0] OPC_WRITE    = 8'h02;
    localparam logic [7:0] OPC_WARMBOOT = 8'h03;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_CHECKSUM = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd2;
    localparam logic [2:0] ERR_BREAK    = 3'd3;
    localparam logic [2:0] ERR_OPCODE   = 3'd4;
    localparam logic [2:0] ERR_SELECT   = 3'd5;
    localparam logic [2:0] ERR_OVERRUN  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OPC  = 3'd1,
        ST_SEL  = 3'd2,
        ST_ADDR = 3'd3,
        ST_DHI  = 3'd4,
        ST_DLO  = 3'd5,
        ST_CHK  = 3'd6
    } state_e;

    // First failing check wins; WARMBOOT ignores the block select.
    function automatic logic [2:0] frame_check(
        input logic [7:0] opcode,
        input logic [7:0] sel,
        input logic [7:0] xor_acc,
        input logic [7:0] chk,
        input logic [8:0] num_blocks,
        input logic       slot_free
    );
        logic [2:0] code;
        if (xor_acc != chk) begin
            code = ERR_CHECKSUM;
        end else if (opcode != OPC_READ && opcode != OPC_WRITE && opcode != OPC_WARMBOOT) begin
            code = ERR_OPCODE;
        end else if (opcode != OPC_WARMBOOT && {1'b0, sel} >= num_blocks) begin
            code = ERR_SELECT;
        end else if (!slot_free) begin
            code = ERR_OVERRUN;
        end else begin
            code = ERR_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/uart_cmd_framer_idle_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags expiry when the count reaches TIMEOUT_CYCLES-1.
module uart_cmd_framer_idle_timer #(
    parameter int TIMEOUT_CYCLES = 12_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign expire_o = enable_i && (count_q == LAST);

    // Next count: clear dominates, hold once expired.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expire_o) begin
            count_d = count_q + TW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_cmd_framer.sv
// Turns the raw UART byte stream into checked command frames and holds one
// decoded command in a valid/ready output slot.
module uart_cmd_framer
    import uart_cmd_framer_pkg::*;
#(
    parameter int MEM_SELECT_BITS = 4,
    parameter int NUM_BLOCKS      = 16,
    parameter int TIMEOUT_CYCLES  = 12_000
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_break,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [7:0]                 cmd_opcode,
    output logic [MEM_SELECT_BITS-1:0] cmd_select,
    output logic [7:0]                 cmd_addr,
    output logic [15:0]                cmd_data,
    output logic                       frame_err,
    output logic [2:0]                 err_code,
    output logic [7:0]                 err_count
);

    state_e                     state_q;
    logic [7:0]                 opc_q, sel_q, addr_q, dhi_q, dlo_q, xor_q;
    logic                       cmd_valid_q;
    logic [7:0]                 cmd_opcode_q;
    logic [MEM_SELECT_BITS-1:0] cmd_select_q;
    logic [7:0]                 cmd_addr_q;
    logic [15:0]                cmd_data_q;
    logic                       frame_err_q;
    logic [2:0]                 err_code_q;
    logic [7:0]                 err_count_q;

    logic       slot_free_s, timer_expire_s, err_s, commit_s;
    logic [2:0] err_code_s, chk_code_s;

    assign slot_free_s = !cmd_valid_q || cmd_ready;

    uart_cmd_framer_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (rx_valid || (state_q == ST_IDLE)),
        .enable_i(state_q != ST_IDLE),
        .expire_o(timer_expire_s)
    );

    // Event arbitration: break beats a byte, a byte beats timeout expiry.
    always_comb begin
        err_s      = 1'b0;
        err_code_s = ERR_NONE;
        commit_s   = 1'b0;
        chk_code_s = frame_check(opc_q, sel_q, xor_q, rx_data, 9'(NUM_BLOCKS), slot_free_s);
        if (rx_break && state_q != ST_IDLE) begin
            err_s      = 1'b1;
            err_code_s = ERR_BREAK;
        end else if (rx_valid && state_q == ST_CHK) begin
            if (chk_code_s != ERR_NONE) begin
                err_s      = 1'b1;
                err_code_s = chk_code_s;
            end else begin
                commit_s = 1'b1;
            end
        end else if (!rx_valid && timer_expire_s) begin
            err_s      = 1'b1;
            err_code_s = ERR_TIMEOUT;
        end else begin
            err_s = 1'b0;
        end
    end

    // Frame FSM, parse registers, output slot and error reporting.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            opc_q        <= 8'h00;
            sel_q        <= 8'h00;
            addr_q       <= 8'h00;
            dhi_q        <= 8'h00;
            dlo_q        <= 8'h00;
            xor_q        <= 8'h00;
            cmd_valid_q  <= 1'b0;
            cmd_opcode_q <= 8'h00;
            cmd_select_q <= '0;
            cmd_addr_q   <= 8'h00;
            cmd_data_q   <= 16'h0000;
            frame_err_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_count_q  <= 8'h00;
        end else begin
            frame_err_q <= err_s;
            if (err_s) begin
                err_code_q <= err_code_s;
                if (err_count_q != 8'hFF) begin
                    err_count_q <= err_count_q + 8'd1;
                end
            end
            if (commit_s) begin
                cmd_valid_q  <= 1'b1;
                cmd_opcode_q <= opc_q;
                cmd_select_q <= sel_q[MEM_SELECT_BITS-1:0];
                cmd_addr_q   <= addr_q;
                cmd_data_q   <= {dhi_q, dlo_q};
            end else if (cmd_valid_q && cmd_ready) begin
                cmd_valid_q <= 1'b0;
            end
            if (err_s) begin
                state_q <= ST_IDLE;
            end else if (rx_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            xor_q   <= 8'h00;
                            state_q <= ST_OPC;
                        end
                    end
                    ST_OPC:  begin opc_q  <= rx_data; xor_q <= xor_q ^ rx_data; state_q <= ST_SEL;  end
                    ST_SEL:  begin sel_q  <= rx_data; xor_q <= xor_q ^ rx_data; state_q <= ST_ADDR; end
                    ST_ADDR: begin addr_q <= rx_data; xor_q <= xor_q ^ rx_data; state_q <= ST_DHI;  end
                    ST_DHI:  begin dhi_q  <= rx_data; xor_q <= xor_q ^ rx_data; state_q <= ST_DLO;  end
                    ST_DLO:  begin dlo_q  <= rx_data; xor_q <= xor_q ^ rx_data; state_q <= ST_CHK;  end
                    ST_CHK:  state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_opcode = cmd_opcode_q;
    assign cmd_select = cmd_select_q;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_data   = cmd_data_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign err_count  = err_count_q;

endmodule
